// File: rtl/seq_divider_unit_pkg.sv
// Shared definitions for the MiniAlu sequential divider: FSM encodings, default width, DIV opcode.
package seq_divider_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2,
        DIV_FIX  = 2'd3
    } divState_t;

    localparam int DIV_DEFAULT_WIDTH = 16;

    // MiniAlu decode value that routes an instruction to this unit
    localparam logic [3:0] DIV_OPCODE = 4'hD;

endpackage

// File: rtl/seq_divider_unit_div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] iRem,
    input  logic             iDividendBit,
    input  logic [WIDTH-1:0] iDivisor,
    output logic [WIDTH-1:0] oRem,
    output logic             oQuotientBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Compare at WIDTH+1 bits: the shifted remainder can exceed the divisor range by one bit
    always_comb begin
        shifted      = {iRem, iDividendBit};
        diff         = shifted - {1'b0, iDivisor};
        oQuotientBit = (shifted >= {1'b0, iDivisor});
        oRem         = oQuotientBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock, done pulse with held results.
// Define DIV_SIGNED_EN for two's-complement operands (adds the one-cycle FIX state).
//
// state    | meaning
// DIV_IDLE | waiting for iStart
// DIV_RUN  | shifting/subtracting, one quotient bit per cycle
// DIV_FIX  | sign correction of magnitude results (DIV_SIGNED_EN only)
// DIV_DONE | oDone pulse; results valid, new request may be accepted
module seq_divider_unit
    import seq_divider_unit_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oDivByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    divState_t        state, stateNext;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] remReg, quoReg, divisorReg;
    logic [WIDTH-1:0] magDividend, magDivisor;
    logic [WIDTH-1:0] stepRem, quoNext;
    logic             stepQ;
    logic             accept, divZero;

`ifdef DIV_SIGNED_EN
    logic negQ, negR;
    assign magDividend = iDividend[WIDTH-1] ? -iDividend : iDividend;
    assign magDivisor  = iDivisor[WIDTH-1]  ? -iDivisor  : iDivisor;
`else
    assign magDividend = iDividend;
    assign magDivisor  = iDivisor;
`endif

    assign accept  = iStart && (state == DIV_IDLE || state == DIV_DONE);
    assign divZero = (iDivisor == '0);
    assign quoNext = {quoReg[WIDTH-2:0], stepQ};

    div_restore_step #(.WIDTH(WIDTH)) uStep (
        .iRem         (remReg),
        .iDividendBit (quoReg[WIDTH-1]),
        .iDivisor     (divisorReg),
        .oRem         (stepRem),
        .oQuotientBit (stepQ)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= DIV_IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        case (state)
            DIV_IDLE, DIV_DONE: begin
                oDone = (state == DIV_DONE);
                if (iStart) stateNext = divZero ? DIV_DONE : DIV_RUN;
                else        stateNext = DIV_IDLE;
            end
            DIV_RUN: begin
                oBusy = 1'b1;
`ifdef DIV_SIGNED_EN
                if (count == '0) stateNext = DIV_FIX;
`else
                if (count == '0) stateNext = DIV_DONE;
`endif
            end
            DIV_FIX: begin
                oBusy     = 1'b1;
                stateNext = DIV_DONE;
            end
            default: stateNext = DIV_IDLE;
        endcase
    end

    // Quotient accumulates in quoReg as the dividend shifts out of its MSB
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDivByZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            negQ       <= 1'b0;
            negR       <= 1'b0;
`endif
        end else if (accept) begin
            count      <= CNT_INIT;
            remReg     <= '0;
            quoReg     <= magDividend;
            divisorReg <= magDivisor;
`ifdef DIV_SIGNED_EN
            negQ       <= iDividend[WIDTH-1] ^ iDivisor[WIDTH-1];
            negR       <= iDividend[WIDTH-1];
`endif
            if (divZero) begin
                oQuotient  <= '1;
                oRemainder <= iDividend;
                oDivByZero <= 1'b1;
            end
        end else if (state == DIV_RUN) begin
            count  <= count - CW'(1);
            remReg <= stepRem;
            quoReg <= quoNext;
`ifndef DIV_SIGNED_EN
            if (count == '0) begin
                oQuotient  <= quoNext;
                oRemainder <= stepRem;
                oDivByZero <= 1'b0;
            end
`endif
        end
`ifdef DIV_SIGNED_EN
        else if (state == DIV_FIX) begin
            oQuotient  <= negQ ? -quoReg : quoReg;
            oRemainder <= negR ? -remReg : remReg;
            oDivByZero <= 1'b0;
        end
`endif
    end

endmodule
